// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer.
//   PC_W       : width of a program counter value
//   INSN_BYTES : byte stride of one sequential fetch
//   seq_state_t: sequencer FSM encoding (BOOT/RUN/REDIR/HALTED)
package pc_seq_pkg;

  localparam int PC_W = 64;
  localparam logic [PC_W-1:0] INSN_BYTES = 64'd4;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REDIR  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect register: holds the target of a taken branch (or trap)
// until instruction memory can accept the redirected fetch.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears the register
//   load  - capture din
//   clear - drop the held target (load wins if both are set)
//   din   - target to capture
//   q     - held target
module pc_redirect_buf
  import pc_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (clear) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: decides each cycle whether the PC register is written and
// with what value (reset vector, sequential fetch, or a pending redirect).
// Optional feature: define PC_SEQ_TRAP_EN to add the trap input and the
// TRAP_VECTOR parameter; a trap redirects to TRAP_VECTOR ahead of br_taken.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   pc_cur              - current PC register value
//   stall               - hazard-unit hold request
//   br_taken, br_target - taken-branch pulse and its target
//   imem_ready          - instruction memory accepts a fetch this cycle
//   halt                - HLT retired, stop sequencing
//   trap                - (PC_SEQ_TRAP_EN only) redirect to TRAP_VECTOR
//   pc_write, pc_next   - PC register write enable and load value
//   flush               - squash IF/ID
//   seq_state           - current FSM state, debug visibility
//
// Handshake: a fetch happens in a cycle where pc_write=1; the sequencer only
// raises pc_write when imem_ready=1 and stall=0 (BOOT excepted, which always
// loads the reset vector). pc_next is forced to 0 whenever pc_write=0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0
`ifdef PC_SEQ_TRAP_EN
  ,
  parameter logic [63:0] TRAP_VECTOR = 64'h400
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_cur,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  input  logic        imem_ready,
  input  logic        halt,
`ifdef PC_SEQ_TRAP_EN
  input  logic        trap,
`endif
  output logic        pc_write,
  output logic [63:0] pc_next,
  output logic        flush,
  output logic [1:0]  seq_state
);

  seq_state_t      state_q;
  seq_state_t      state_d;
  logic            redir_req;
  logic [PC_W-1:0] redir_tgt;
  logic            pend_load;
  logic            pend_clear;
  logic [PC_W-1:0] pend_tgt;

  // A redirect request merges the branch and (optionally) the trap source;
  // the trap target wins when both fire in the same cycle.
`ifdef PC_SEQ_TRAP_EN
  assign redir_req = trap | br_taken;
  assign redir_tgt = trap ? TRAP_VECTOR : br_target;
`else
  assign redir_req = br_taken;
  assign redir_tgt = br_target;
`endif

  pc_redirect_buf u_redirect_buf (
    .clk   (clk),
    .reset (reset),
    .load  (pend_load),
    .clear (pend_clear),
    .din   (redir_tgt),
    .q     (pend_tgt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_next    = '0;
    flush      = 1'b0;
    pend_load  = 1'b0;
    pend_clear = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_write = 1'b1;
        pc_next  = RESET_VECTOR;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (redir_req) begin
          pend_load = 1'b1;
          flush     = 1'b1;
          state_d   = ST_REDIR;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (!stall && imem_ready) begin
          pc_write = 1'b1;
          pc_next  = pc_cur + INSN_BYTES;
        end
      end
      ST_REDIR: begin
        // A newer redirect replaces the older pending one.
        if (redir_req) begin
          pend_load = 1'b1;
          flush     = 1'b1;
        end else if (imem_ready && !stall) begin
          pc_write   = 1'b1;
          pc_next    = pend_tgt;
          pend_clear = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Reset quiets every output in the same cycle it is asserted.
    if (reset) begin
      pc_write   = 1'b0;
      pc_next    = '0;
      flush      = 1'b0;
      pend_load  = 1'b0;
      pend_clear = 1'b0;
    end
  end

  assign seq_state = reset ? 2'(ST_BOOT) : 2'(state_q);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: pc_cur  in  64  current PC from the PC register.
REQ-004 SHALL have ports: stall  in  1  hazard-unit hold request.
REQ-005 SHALL have ports: br_taken  in  1  branch resolved taken, one-cycle pulse.
REQ-006 SHALL have ports: br_target  in  64  branch target, valid with br_taken.
REQ-007 SHALL have ports: imem_ready  in  1  instruction memory accepts a fetch this cycle.
REQ-008 SHALL have ports: halt  in  1  stop sequencing (HLT retired).
REQ-009 SHALL have ports: pc_write  out  1  write enable to the PC register.
REQ-010 SHALL have ports: pc_next  out  64  value to load into the PC register.
REQ-011 SHALL have ports: flush  out  1  squash the IF/ID stage.
REQ-012 SHALL have ports: seq_state  out  2  current FSM state, for debug.
REQ-013 SHALL have parameter RESET_VECTOR, default 64'h0, meaning the first fetch address after reset.

Function
REQ-014 SHALL implement a registered FSM with four states: BOOT=0, RUN=1, REDIR=2, HALTED=3.
REQ-015 BOOT SHALL last exactly one cycle, drive pc_write=1 and pc_next=RESET_VECTOR, then go to RUN.
REQ-016 In RUN with halt=1, SHALL drive pc_write=0 and go to HALTED; halt has priority over stall and sequential fetch, but not over br_taken.
REQ-017 In RUN with br_taken=1, SHALL latch br_target into the pending-redirect register, assert flush in that same cycle, and go to REDIR; br_taken has priority over halt, stall and sequential fetch.
REQ-018 In RUN with stall=1 or imem_ready=0 (and no br_taken or halt), SHALL drive pc_write=0 and stay in RUN.
REQ-019 In RUN otherwise, SHALL drive pc_write=1 and pc_next=pc_cur+64'd4, with modulo-2^64 wrap.
REQ-020 In REDIR with imem_ready=1 and stall=0, SHALL drive pc_write=1 and pc_next=pending target, then return to RUN.
REQ-021 In REDIR otherwise, SHALL hold: pc_write=0, pending target unchanged.
REQ-022 A br_taken arriving while in REDIR SHALL overwrite the pending target, assert flush, and stay in REDIR.
REQ-023 HALTED SHALL be left only by reset: pc_write=0, br_taken ignored, flush=0.
REQ-024 pc_write, pc_next and flush SHALL be combinational from the registered state and the current inputs, giving zero-cycle latency to the PC register.
REQ-025 pc_next SHALL be 0 whenever pc_write=0.

Reset
REQ-026 reset=1 at a clock edge SHALL set state to BOOT and clear the pending target, overriding all other inputs, mid-redirect included.
REQ-027 While reset=1: pc_write=0, flush=0, pc_next=0, seq_state=BOOT.

Configuration
REQ-028 SHALL define the macro PC_SEQ_TRAP_EN, which compiles the trap feature in or out.
REQ-029 With PC_SEQ_TRAP_EN defined, SHALL add input trap (1 bit) and parameter TRAP_VECTOR (default 64'h400).
REQ-030 With PC_SEQ_TRAP_EN defined, trap=1 in RUN or REDIR SHALL act as a redirect to TRAP_VECTOR with priority above br_taken, and trap SHALL be ignored in HALTED.
REQ-031 Without PC_SEQ_TRAP_EN, the trap port SHALL be absent and behaviour SHALL be exactly as in REQ-014 to REQ-027.

Structure
REQ-032 A shared package pc_seq_pkg SHALL hold the state encodings, the 64-bit PC width constant, and the instruction-size constant (4).
REQ-033 The pending-redirect register SHALL be a sub-module named pc_redirect_buf: 64-bit, load/clear, synchronous reset.
REQ-034 No further hierarchy.

Verification
REQ-035 SHALL cover: reset held for 2 cycles, then released -> one BOOT cycle with pc_next=0 and pc_write=1, then RUN with pc_cur=0 giving pc_next=4.
REQ-036 SHALL cover: pc_cur=64'hFFFF_FFFF_FFFF_FFFC in RUN -> pc_next=0 (wrap).
REQ-037 SHALL cover: br_taken with target 64'h1000 while imem_ready=0 for 3 cycles -> flush pulses once, pc_write=0 for 3 cycles, then pc_write=1 with pc_next=64'h1000.
REQ-038 SHALL cover: br_taken (64'h2000) in the same cycle as halt -> REDIR taken and flush=1; then halt alone in RUN -> HALTED, and a later br_taken gives no pc_write.
REQ-039 SHALL cover: reset asserted while in REDIR with a pending target -> BOOT next cycle, pending target cleared, pc_next=RESET_VECTOR.
REQ-040 SHALL cover, with PC_SEQ_TRAP_EN: trap and br_taken in the same cycle -> pc_next=64'h400 on the redirect.
